// File: rtl/cmos_dvp_pkg.sv
// Shared types and default timing for the DVP transmitter.
// Counter width is sized for the default 800-clock line and 510-line frame.
package cmos_dvp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_BACK   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_FRONT  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_STREAM = 2'd0,
      MODE_RAMP   = 2'd1,
      MODE_BARS   = 2'd2,
      MODE_CONST  = 2'd3
   } mode_t;

   localparam int         CNT_W          = 16;
   localparam int         DEF_H_ACTIVE   = 640;
   localparam int         DEF_H_BLANK    = 160;
   localparam int         DEF_V_SYNC     = 3;
   localparam int         DEF_V_BACK     = 17;
   localparam int         DEF_V_ACTIVE   = 480;
   localparam int         DEF_V_FRONT    = 10;
   localparam logic [7:0] DEF_FILL_DATA  = 8'h00;
   localparam logic [7:0] BAR_STEP       = 8'd36;

endpackage

// File: rtl/cmos_dvp_tx_if.sv
// Pixel stream in and DVP bus out; master is the transmitter side.
interface cmos_dvp_tx_if;
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       pix_ready;
   logic       cmos_vsync;
   logic       cmos_href;
   logic [7:0] cmos_data;

   modport master (
      input  pix_data, pix_valid,
      output pix_ready, cmos_vsync, cmos_href, cmos_data
   );

   modport slave (
      output pix_data, pix_valid,
      input  pix_ready, cmos_vsync, cmos_href, cmos_data
   );
endinterface

// File: rtl/cmos_dvp_timing.sv
// Frame state machine with line/pixel counters; all outputs are decoded from
// registered state so the transmitter can register them one cycle later.
module cmos_dvp_timing
   import cmos_dvp_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_BLANK  = DEF_H_BLANK,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT
) (
   input  logic             cmos_pclk,
   input  logic             rst,
   input  logic             enable,
   output state_t           state,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             active,
   output logic             frame_start,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_ACTIVE + H_BLANK - 1);
   localparam logic [CNT_W-1:0] H_ACT_LEN   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(V_SYNC - 1);
   localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'((V_BACK > 0) ? V_BACK - 1 : 0);
   localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] FRONT_LAST  = CNT_W'((V_FRONT > 0) ? V_FRONT - 1 : 0);

   state_t           state_r, state_n;
   logic [CNT_W-1:0] h_cnt_r, h_cnt_n;
   logic [CNT_W-1:0] v_cnt_r, v_cnt_n;
   logic             line_end_s, last_line_s, start_s, end_s;

   assign line_end_s = (h_cnt_r == H_LAST);

   // Last line of the current state
   always_comb begin
      last_line_s = 1'b0;
      case (state_r)
         ST_SYNC:   last_line_s = (v_cnt_r == SYNC_LAST);
         ST_BACK:   last_line_s = (v_cnt_r == BACK_LAST);
         ST_ACTIVE: last_line_s = (v_cnt_r == ACTIVE_LAST);
         ST_FRONT:  last_line_s = (v_cnt_r == FRONT_LAST);
         default:   last_line_s = 1'b0;
      endcase
   end

   // Next state and counters; zero-length BACK/FRONT are skipped outright
   always_comb begin
      state_n = state_r;
      h_cnt_n = h_cnt_r;
      v_cnt_n = v_cnt_r;
      start_s = 1'b0;
      end_s   = 1'b0;
      if (state_r == ST_IDLE) begin
         h_cnt_n = {CNT_W{1'b0}};
         v_cnt_n = {CNT_W{1'b0}};
         if (enable) begin
            state_n = ST_SYNC;
            start_s = 1'b1;
         end else begin
            state_n = ST_IDLE;
         end
      end else if (line_end_s) begin
         h_cnt_n = {CNT_W{1'b0}};
         if (last_line_s) begin
            v_cnt_n = {CNT_W{1'b0}};
            case (state_r)
               ST_SYNC:   state_n = (V_BACK > 0) ? ST_BACK : ST_ACTIVE;
               ST_BACK:   state_n = ST_ACTIVE;
               ST_ACTIVE: begin
                  if (V_FRONT > 0) begin
                     state_n = ST_FRONT;
                  end else begin
                     end_s   = 1'b1;
                     start_s = enable;
                     state_n = enable ? ST_SYNC : ST_IDLE;
                  end
               end
               ST_FRONT: begin
                  end_s   = 1'b1;
                  start_s = enable;
                  state_n = enable ? ST_SYNC : ST_IDLE;
               end
               default:   state_n = ST_IDLE;
            endcase
         end else begin
            v_cnt_n = v_cnt_r + CNT_W'(1);
         end
      end else begin
         h_cnt_n = h_cnt_r + CNT_W'(1);
      end
   end

   // State and counter registers
   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         h_cnt_r <= {CNT_W{1'b0}};
         v_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_n;
         h_cnt_r <= h_cnt_n;
         v_cnt_r <= v_cnt_n;
      end
   end

   assign state       = state_r;
   assign h_cnt       = h_cnt_r;
   assign v_cnt       = v_cnt_r;
   assign active      = (state_r == ST_ACTIVE) && (h_cnt_r < H_ACT_LEN);
   assign frame_start = start_s;
   assign frame_end   = end_s;

endmodule

// File: rtl/cmos_dvp_tx.sv
// DVP transmitter: pattern/stream mux, upstream handshake and registered
// VSYNC/HREF/data outputs. Underflow is filled, never waited on.
module cmos_dvp_tx
   import cmos_dvp_pkg::*;
#(
   parameter int         H_ACTIVE  = DEF_H_ACTIVE,
   parameter int         H_BLANK   = DEF_H_BLANK,
   parameter int         V_SYNC    = DEF_V_SYNC,
   parameter int         V_BACK    = DEF_V_BACK,
   parameter int         V_ACTIVE  = DEF_V_ACTIVE,
   parameter int         V_FRONT   = DEF_V_FRONT,
   parameter logic [7:0] FILL_DATA = DEF_FILL_DATA
) (
   input  logic          cmos_pclk,
   input  logic          rst,
   input  logic          enable,
   input  logic [1:0]    mode,
   input  logic [7:0]    const_data,
   cmos_dvp_tx_if.master dvp,
   output logic [15:0]   frame_cnt,
   output logic          frame_done,
   output logic          underflow,
   output logic          busy
);

   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

   state_t           state_s;
   logic [CNT_W-1:0] h_cnt_s, v_cnt_s;
   logic             active_s, frame_start_s, frame_end_s, pix_ready_s;
   mode_t            mode_r;
   logic [7:0]       const_r, pat_byte_s, bar_val_r;
   logic [CNT_W-1:0] bar_pix_r;
   logic [15:0]      frame_cnt_r;
   logic             frame_done_r, underflow_r, busy_r;

   cmos_dvp_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT)
   ) u_timing (
      .cmos_pclk   (cmos_pclk),
      .rst         (rst),
      .enable      (enable),
      .state       (state_s),
      .h_cnt       (h_cnt_s),
      .v_cnt       (v_cnt_s),
      .active      (active_s),
      .frame_start (frame_start_s),
      .frame_end   (frame_end_s)
   );

   assign pix_ready_s   = active_s && (mode_r == MODE_STREAM);
   assign dvp.pix_ready = pix_ready_s;

   // Mode and constant are frozen for the whole frame
   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         mode_r  <= MODE_STREAM;
         const_r <= 8'h00;
      end else if (frame_start_s) begin
         mode_r  <= mode_t'(mode);
         const_r <= const_data;
      end else begin
         mode_r  <= mode_r;
         const_r <= const_r;
      end
   end

   // Bar value steps by BAR_STEP every H_ACTIVE/8 pixels, restarting each line
   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         bar_pix_r <= {CNT_W{1'b0}};
         bar_val_r <= 8'h00;
      end else if (active_s) begin
         if (bar_pix_r == BAR_LAST) begin
            bar_pix_r <= {CNT_W{1'b0}};
            bar_val_r <= bar_val_r + BAR_STEP;
         end else begin
            bar_pix_r <= bar_pix_r + CNT_W'(1);
         end
      end else begin
         bar_pix_r <= {CNT_W{1'b0}};
         bar_val_r <= 8'h00;
      end
   end

   // Pattern byte for the current pixel
   always_comb begin
      pat_byte_s = 8'h00;
      case (mode_r)
         MODE_STREAM: begin
            if (dvp.pix_valid) begin
               pat_byte_s = dvp.pix_data;
            end else begin
               pat_byte_s = FILL_DATA;
            end
         end
         MODE_RAMP:   pat_byte_s = h_cnt_s[7:0] + v_cnt_s[7:0] + frame_cnt_r[7:0];
         MODE_BARS:   pat_byte_s = bar_val_r;
         MODE_CONST:  pat_byte_s = const_r;
         default:     pat_byte_s = 8'h00;
      endcase
   end

   // Output registers and flags
   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         dvp.cmos_vsync <= 1'b0;
         dvp.cmos_href  <= 1'b0;
         dvp.cmos_data  <= 8'h00;
         frame_cnt_r    <= 16'd0;
         frame_done_r   <= 1'b0;
         underflow_r    <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         dvp.cmos_vsync <= (state_s == ST_BACK) || (state_s == ST_ACTIVE) || (state_s == ST_FRONT);
         dvp.cmos_href  <= active_s;
         dvp.cmos_data  <= active_s ? pat_byte_s : 8'h00;
         frame_cnt_r    <= frame_end_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
         frame_done_r   <= frame_end_s;
         underflow_r    <= underflow_r || (pix_ready_s && !dvp.pix_valid);
         busy_r         <= (state_s != ST_IDLE);
      end
   end

   assign frame_cnt  = frame_cnt_r;
   assign frame_done = frame_done_r;
   assign underflow  = underflow_r;
   assign busy       = busy_r;

endmodule

// File: doc/cmos_dvp_tx.md
# cmos_dvp_tx

DVP (camera parallel port) transmitter that emits the same VSYNC/HREF/8-bit data waveform our OmniVision sensors produce: VSYNC low for the frame sync, high across the frame, and HREF high per active line. Pixels come either from an upstream valid/ready stream or from built-in gray test patterns. It drives CMOS_Capture_RAW_Gray and the SGM pipeline in simulation and on-board loopback when no sensor is fitted. Timing never stalls: upstream underflow is filled and flagged, not waited on.

## Interface
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8 and at least 8.
- H_BLANK, 160, blank clocks per line (HREF low); at least 1.
- V_SYNC, 3, lines with VSYNC low at frame start; at least 1.
- V_BACK, 17, lines with VSYNC high and no HREF, after sync.
- V_ACTIVE, 480, active lines.
- V_FRONT, 10, lines with VSYNC high and no HREF, after active.
- FILL_DATA, 8'h00, byte sent on underflow.
- cmos_pclk  input  1  pixel clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  level; frames run while high.
- mode  input  2  0 = stream, 1 = ramp, 2 = bars, 3 = constant; sampled at frame start.
- const_data  input  8  byte for mode 3; sampled at frame start.
- pix_data  input  8  upstream pixel.
- pix_valid  input  1  upstream valid.
- pix_ready  output  1  pixel consumed this cycle (mode 0 only).
- cmos_vsync  output  1  registered frame sync.
- cmos_href  output  1  registered line valid.
- cmos_data  output  8  registered pixel byte.
- frame_cnt  output  16  completed frames, wraps at 65535 to 0.
- frame_done  output  1  one-cycle pulse on the last cycle of each frame.
- underflow  output  1  sticky; cleared only by rst.
- busy  output  1  high from frame start to frame end.

## Operation
- States: IDLE, SYNC, BACK, ACTIVE, FRONT.
- Counters: h_cnt runs 0..H_ACTIVE+H_BLANK-1 and wraps. v_cnt counts lines within the current state.
- IDLE: counters held at 0. When enable=1, the block latches mode and const_data and enters SYNC at h_cnt=0.
- SYNC → BACK → ACTIVE → FRONT: each transition happens after that state's line count, on the h_cnt wrap.
- FRONT end: the block pulses frame_done and increments frame_cnt. If enable=1 it goes to SYNC, re-latching mode and const_data. Otherwise it goes to IDLE.
- Dropping enable mid-frame: the current frame always completes. Frames are never truncated.
- Zero-length states: V_BACK=0 or V_FRONT=0 skips that state.
- Active pixel: state=ACTIVE and h_cnt<H_ACTIVE.
- Mode 0 (stream): pix_ready=1 exactly on active-pixel cycles, decoded from registered state. If pix_valid=1, the byte sent is pix_data. If pix_valid=0, the byte sent is FILL_DATA and underflow is set. pix_ready=0 in every other mode and cycle.
- Mode 1 (ramp): byte = h_cnt[7:0] + v_cnt[7:0] + frame_cnt[7:0], mod 256.
- Mode 2 (bars): 8 equal vertical bars of H_ACTIVE/8 pixels. Byte = bar_idx × 36, giving 0, 36, …, 252. bar_idx comes from a sub-counter; no divider.
- Mode 3 (constant): byte = latched const_data.
- Output registers: cmos_vsync=0 in IDLE and SYNC, 1 in BACK, ACTIVE and FRONT. cmos_href=1 only for an active pixel. cmos_data = the pattern byte when active, 0 otherwise.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, underflow 0.
- Reset mid-frame: the next cycle shows cmos_vsync=0 and cmos_href=0 with no partial-line completion.
- Latency: an active-pixel decision or pix_ready handshake in cycle N appears on cmos_href/cmos_data in cycle N+1. The same 1-cycle latency applies to cmos_vsync edges and busy.
- Line period: H_ACTIVE+H_BLANK cycles. Frame period: (V_SYNC+V_BACK+V_ACTIVE+V_FRONT) line periods. Back-to-back frames have zero gap.
- VSYNC edges align to h_cnt=0. The first HREF rise of a frame comes exactly V_BACK lines after the VSYNC rise.
- frame_done and the frame_cnt increment happen in the same cycle (the last cycle of FRONT, pre-register). frame_done is registered with the outputs.
- enable rising during FRONT has no effect; the continue/stop decision is made at the FRONT end.

## Structure
- Package cmos_dvp_pkg: the state enum, the mode enum (MODE_STREAM, MODE_RAMP, MODE_BARS, MODE_CONST), the default timing constants, and BAR_STEP=36.
- Sub-module cmos_dvp_timing: state machine, h/v counters, active decode, frame_done.
- cmos_dvp_tx: pattern mux, handshake, output registers and flags.

## Test plan
All scenarios use H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1, so one frame is 60 cycles.
- Reset then enable=1, mode=3, const_data=8'hA5 → cmos_vsync low 12 cycles then high 48. Two HREF bursts of 8 × 8'hA5. frame_done every 60 cycles. frame_cnt = 1, 2, 3.
- Mode 0 with pix_valid always 1 and data 0..15 → 16 bytes out in order, one cycle after each pix_ready. underflow stays 0.
- Mode 0 with pix_valid low on the 3rd active pixel → that byte is 8'h00. underflow=1 and stays high. The following pixels shift by none.
- Mode 2 → each active line is 0, 36, 72, 108, 144, 180, 216, 252.
- enable dropped at cycle 20 of frame 1 → the frame completes at cycle 60, then outputs stay 0 and busy=0. Re-enable starts a fresh SYNC.
- rst asserted mid-ACTIVE → the next cycle shows all outputs 0. Loopback into CMOS_Capture_RAW_Gray (CMOS_FRAME_WAITCNT=1) reproduces 8×2 frames exactly.
